// File: rtl/ym3438_sample_mixer_if.sv
// Slot-input / PCM-output bundle for ym3438_sample_mixer.
//   master: the slot producer and the PCM consumer (drives slots, pcm_ready, err_clr).
//   slave : the mixer (drives the PCM frame and the error status).
// The signal names match the original flat port list.
interface ym3438_sample_mixer_if;
  logic        slot_valid;
  logic        slot_first;
  logic [8:0]  mol;
  logic [8:0]  mor;
  logic [15:0] pcm_l;
  logic [15:0] pcm_r;
  logic        pcm_valid;
  logic        pcm_ready;
  logic        sync_err;
  logic        overrun;
  logic [7:0]  drop_cnt;
  logic        err_clr;

  modport master (
    output slot_valid, slot_first, mol, mor, pcm_ready, err_clr,
    input  pcm_l, pcm_r, pcm_valid, sync_err, overrun, drop_cnt
  );

  modport slave (
    input  slot_valid, slot_first, mol, mor, pcm_ready, err_clr,
    output pcm_l, pcm_r, pcm_valid, sync_err, overrun, drop_cnt
  );
endinterface

// File: rtl/ym3438_sample_mixer.sv
// ym3438_sample_mixer: sums CHANNELS time-multiplexed offset-binary MOL/MOR
// slots into one stereo frame. The frame is scaled by GAIN_SHIFT, saturated
// to 16-bit PCM and offered on a valid/ready port. The block also flags
// frame-sync errors and output overruns.
// Ports:
//   MCLK   - clock; all state updates on the rising edge
//   reset  - synchronous, active-high
//   mix    - slave side of ym3438_sample_mixer_if:
//            slot_valid/slot_first/mol/mor   slot input
//            pcm_l/pcm_r/pcm_valid/pcm_ready frame output handshake
//            sync_err/overrun/drop_cnt       sticky status, cleared by err_clr
module ym3438_sample_mixer #(
  parameter int unsigned CHANNELS   = 6,
  parameter int unsigned GAIN_SHIFT = 4
) (
  input logic                   MCLK,
  input logic                   reset,
  ym3438_sample_mixer_if.slave  mix
);

  typedef enum logic {UNSYNC, ACC} state_e;

  localparam logic [3:0] CHAN_CNT = 4'(CHANNELS);

  state_e             state_q;
  logic [3:0]         cnt_q;
  logic signed [11:0] acc_l_q, acc_r_q;
  logic [15:0]        pcm_l_q, pcm_r_q;
  logic               pcm_valid_q;
  logic               sync_err_q;
  logic               overrun_q;
  logic [7:0]         drop_cnt_q;

  logic signed [11:0] s_l, s_r;
  logic signed [11:0] sum_l, sum_r;
  logic [15:0]        sat_l, sat_r;
  logic [3:0]         cnt_inc;
  logic               first_ev, next_ev, in_acc;
  logic               commit, sync_ev, drop, load;

  // Shift into a 20-bit signed intermediate and clamp to the 16-bit range.
  function automatic logic [15:0] sat16(input logic signed [11:0] a);
    logic signed [19:0] t;
    t = {{8{a[11]}}, a};
    t = t <<< GAIN_SHIFT;
    if (t > 20'sd32767)
      return 16'h7FFF;
    else if (t < -20'sd32768)
      return 16'h8000;
    else
      return t[15:0];
  endfunction

  always_comb begin
    // Offset binary to two's complement: invert the MSB, then sign-extend.
    s_l      = {{3{~mix.mol[8]}}, ~mix.mol[8], mix.mol[7:0]};
    s_r      = {{3{~mix.mor[8]}}, ~mix.mor[8], mix.mor[7:0]};
    sum_l    = acc_l_q + s_l;
    sum_r    = acc_r_q + s_r;
    sat_l    = sat16(sum_l);
    sat_r    = sat16(sum_r);
    cnt_inc  = cnt_q + 4'd1;
    in_acc   = (state_q == ACC);
    first_ev = mix.slot_valid & mix.slot_first;
    next_ev  = mix.slot_valid & ~mix.slot_first;
    // CHANNELS >= 2, so a commit can only come from a non-first slot.
    commit   = in_acc & next_ev & (cnt_q != '0) & (cnt_inc == CHAN_CNT);
    sync_ev  = in_acc & ((first_ev & (cnt_q != '0)) | (next_ev & (cnt_q == '0)));
    drop     = commit & pcm_valid_q & ~mix.pcm_ready;
    load     = commit & ~drop;
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_q     <= UNSYNC;
      cnt_q       <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      pcm_l_q     <= '0;
      pcm_r_q     <= '0;
      pcm_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      overrun_q   <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      case (state_q)
        UNSYNC: begin
          if (first_ev) begin
            acc_l_q <= s_l;
            acc_r_q <= s_r;
            cnt_q   <= 4'd1;
            state_q <= ACC;
          end
        end
        ACC: begin
          if (first_ev) begin
            // A first slot always restarts the frame; any partial sum is lost.
            acc_l_q <= s_l;
            acc_r_q <= s_r;
            cnt_q   <= 4'd1;
          end else if (next_ev) begin
            if (cnt_q == '0) begin
              state_q <= UNSYNC;
            end else if (commit) begin
              acc_l_q <= '0;
              acc_r_q <= '0;
              cnt_q   <= '0;
            end else begin
              acc_l_q <= sum_l;
              acc_r_q <= sum_r;
              cnt_q   <= cnt_inc;
            end
          end
        end
        default: state_q <= UNSYNC;
      endcase

      if (load) begin
        pcm_l_q     <= sat_l;
        pcm_r_q     <= sat_r;
        pcm_valid_q <= 1'b1;
      end else if (!commit && pcm_valid_q && mix.pcm_ready) begin
        pcm_valid_q <= 1'b0;
      end

      // Error events take priority over err_clr in the same cycle.
      if (sync_ev)
        sync_err_q <= 1'b1;
      else if (mix.err_clr)
        sync_err_q <= 1'b0;

      if (drop)
        overrun_q <= 1'b1;
      else if (mix.err_clr)
        overrun_q <= 1'b0;

      if (drop) begin
        if (mix.err_clr)
          drop_cnt_q <= 8'd1;
        else if (drop_cnt_q != 8'hFF)
          drop_cnt_q <= drop_cnt_q + 8'd1;
      end else if (mix.err_clr) begin
        drop_cnt_q <= '0;
      end
    end
  end

  assign mix.pcm_l     = pcm_l_q;
  assign mix.pcm_r     = pcm_r_q;
  assign mix.pcm_valid = pcm_valid_q;
  assign mix.sync_err  = sync_err_q;
  assign mix.overrun   = overrun_q;
  assign mix.drop_cnt  = drop_cnt_q;

endmodule
